// File: rtl/rcvr_ctrl.sv
// rcvr_ctrl: controller and byte FIFO between the serial match receiver and
// a byte consumer.
//  - Two-state FSM (IDLE/ACK) issues a one-cycle rx_reading acknowledge for
//    every byte it takes from the receiver.
//  - Each captured byte goes into a DEPTH-entry first-word-fall-through FIFO,
//    presented downstream on out_valid/out_ready.
//  - ovr_count counts rising edges of rx_overrun and saturates at all-ones.
// Optional feature, macro RCVR_CTRL_DROP_EN:
//  - Defined: a byte arriving while the FIFO is full is still acknowledged,
//    then discarded and counted in drop_count. The receiver never stalls.
//  - Undefined: the controller holds off, so the receiver may overrun.
//    drop_count is tied to zero.
module rcvr_ctrl #(
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     rx_ready,
    input  logic                     rx_overrun,
    input  logic [7:0]               rx_data,
    output logic                     rx_reading,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CW-1:0]            ovr_count,
    output logic [CW-1:0]            drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            r_reading;
    logic            w_reading_next;
    logic            w_push;
    logic            w_pop;
    logic            w_full;

    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_count;

    logic            r_ovr_prev;
    logic [CW-1:0]   r_ovr_count;

`ifdef RCVR_CTRL_DROP_EN
    logic            w_drop;
    logic [CW-1:0]   r_drop_count;
`endif

    // Occupancy comes from the counter, so it can tell full from empty even
    // though the pointers wrap onto each other.
    assign w_full     = (r_count == FULL_LEVEL);
    assign out_valid  = (r_count != '0);
    assign w_pop      = out_valid && out_ready;
    assign out_data   = r_mem[r_rd_ptr];
    assign fifo_level = r_count;
    assign rx_reading = r_reading;
    assign ovr_count  = r_ovr_count;

    // Next-state and capture decision: accept a byte only in IDLE.
    always_comb begin
        // NOTE: every output of this block gets a default before the case, so
        // no path leaves one unassigned and no latch is inferred.
        w_next_state   = r_state;
        w_reading_next = 1'b0;
        w_push         = 1'b0;
`ifdef RCVR_CTRL_DROP_EN
        w_drop         = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (rx_ready) begin
                    if (!w_full) begin
                        w_push         = 1'b1;
                        w_reading_next = 1'b1;
                        w_next_state   = ACK;
                    end
`ifdef RCVR_CTRL_DROP_EN
                    else begin
                        w_drop         = 1'b1;
                        w_reading_next = 1'b1;
                        w_next_state   = ACK;
                    end
`endif
                end
            end
            ACK:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State register and the registered acknowledge pulse.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before the edge.
        if (!reset) begin
            r_state   <= IDLE;
            r_reading <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_reading <= w_reading_next;
        end
    end

    // FIFO storage: data only, written when a byte is accepted and not flushed.
    always_ff @(posedge clock) begin
        // NOTE: the storage array has no reset. out_valid masks stale
        // contents, and leaving it unreset keeps it a plain RAM.
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    // FIFO pointers and occupancy. A flush takes priority over push and pop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Saturating count of rx_overrun rising edges. A held level counts once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ovr_prev  <= 1'b0;
            r_ovr_count <= '0;
        end else begin
            r_ovr_prev <= rx_overrun;
            if (rx_overrun && !r_ovr_prev && (r_ovr_count != '1)) begin
                r_ovr_count <= r_ovr_count + 1'b1;
            end
        end
    end

`ifdef RCVR_CTRL_DROP_EN
    // Saturating count of bytes acknowledged while the FIFO was full.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != '1)) begin
            r_drop_count <= r_drop_count + 1'b1;
        end
    end

    assign drop_count = r_drop_count;
`else
    assign drop_count = '0;
`endif

endmodule
